// File: rtl/rfblackwidow_dcache_fill_ctrl.sv
// Data-cache line-fill sequencer: picks a victim way, fetches a line beat by beat
// over the bus and streams each beat into the chosen way.
module rfblackwidow_dcache_fill_ctrl #(
  parameter int          WAYS  = 4,
  parameter int          BEATS = 4,
  parameter int          AW    = 32,
  parameter int          DW    = 128,
  parameter logic [15:0] SEED  = 16'hACE1,
  localparam int         BW    = $clog2(BEATS)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_miss_req,
  input  logic [AW-1:0]   i_miss_adr,
  input  logic [WAYS-1:0] i_set_valid,
  input  logic            i_abort,
  output logic            o_miss_ack,
  output logic            o_bus_cyc,
  output logic            o_bus_stb,
  output logic [AW-1:0]   o_bus_adr,
  input  logic            i_bus_ack,
  input  logic            i_bus_err,
  input  logic [DW-1:0]   i_bus_dat,
  output logic [1:0]      o_wway,
  output logic            o_cache_we,
  output logic [BW-1:0]   o_cache_beat,
  output logic [DW-1:0]   o_cache_dat,
  output logic            o_fill_done,
  output logic            o_fill_err,
  output logic            o_busy
);

  localparam int BSH = $clog2(DW/8);
  localparam int LSH = $clog2(BEATS*DW/8);
  localparam logic [AW-1:0] LMASK = ~((AW'(1) << LSH) - AW'(1));

  typedef enum logic [2:0] {
    S_IDLE, S_VICTIM, S_REQ, S_WAIT, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_line;
  logic [WAYS-1:0] r_valid;
  logic [BW-1:0]   r_beat;
  logic [15:0]     r_lfsr;

  logic            w_has_free;
  logic [1:0]      w_free_way;
  logic [BW-1:0]   w_beat_nxt;
  logic            w_lfsr_fb;

  assign w_beat_nxt = r_beat + BW'(1);
  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign o_busy     = (r_state != S_IDLE);

  // Lowest invalid way wins; scan downward so the last hit is the lowest index.
  always_comb begin
    w_has_free = 1'b0;
    w_free_way = 2'd0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_way = 2'(i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_lfsr <= SEED;
    else       r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_line       <= '0;
      r_valid      <= '0;
      r_beat       <= '0;
      o_miss_ack   <= 1'b0;
      o_bus_cyc    <= 1'b0;
      o_bus_stb    <= 1'b0;
      o_bus_adr    <= '0;
      o_wway       <= '0;
      o_cache_we   <= 1'b0;
      o_cache_beat <= '0;
      o_cache_dat  <= '0;
      o_fill_done  <= 1'b0;
      o_fill_err   <= 1'b0;
    end else if (i_abort && r_state != S_IDLE) begin
      // Abort wins over a same-cycle bus_ack, so that beat is dropped.
      r_state     <= S_IDLE;
      o_miss_ack  <= 1'b0;
      o_bus_cyc   <= 1'b0;
      o_bus_stb   <= 1'b0;
      o_cache_we  <= 1'b0;
      o_fill_done <= 1'b0;
      o_fill_err  <= 1'b0;
    end else begin
      o_miss_ack  <= 1'b0;
      o_cache_we  <= 1'b0;
      o_fill_done <= 1'b0;
      o_fill_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_miss_req) begin
            r_line     <= i_miss_adr & LMASK;
            r_valid    <= i_set_valid;
            o_miss_ack <= 1'b1;
            r_state    <= S_VICTIM;
          end
        end
        S_VICTIM: begin
          o_wway    <= w_has_free ? w_free_way : r_lfsr[1:0];
          r_beat    <= '0;
          o_bus_cyc <= 1'b1;
          o_bus_stb <= 1'b1;
          o_bus_adr <= r_line;
          r_state   <= S_REQ;
        end
        S_REQ: r_state <= S_WAIT;
        S_WAIT: begin
          if (i_bus_err) begin
            o_bus_cyc  <= 1'b0;
            o_bus_stb  <= 1'b0;
            o_fill_err <= 1'b1;
            r_state    <= S_ERR;
          end else if (i_bus_ack) begin
            o_cache_dat  <= i_bus_dat;
            o_bus_stb    <= 1'b0;
            o_cache_we   <= 1'b1;
            o_cache_beat <= r_beat;
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_beat == BW'(BEATS-1)) begin
            o_bus_cyc   <= 1'b0;
            o_fill_done <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_beat    <= w_beat_nxt;
            o_bus_stb <= 1'b1;
            o_bus_adr <= r_line | (AW'(w_beat_nxt) << BSH);
            r_state   <= S_REQ;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rfblackwidow_dcache_fill_ctrl.sv
// Bench for the dcache fill sequencer: bus responder, LFSR reference and a
// write scoreboard that expects (way, beat, address, data) per cache_we.
module tb_rfblackwidow_dcache_fill_ctrl;
  localparam int DW = 128;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0, rst = 1'b1, miss_req = 1'b0, abort = 1'b0;
  logic [31:0]   miss_adr = '0;
  logic [3:0]    set_valid = '0;
  logic          o_miss_ack, o_bus_cyc, o_bus_stb, o_cache_we, o_fill_done, o_fill_err, o_busy;
  logic [31:0]   o_bus_adr;
  logic [1:0]    o_wway, o_cache_beat;
  logic [DW-1:0] o_cache_dat, bus_dat;
  logic          bus_ack, bus_err;

  int tests = 0, fails = 0;
  int cycle = 0, n_we = 0, n_ack = 0, first_we_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  rfblackwidow_dcache_fill_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_miss_req(miss_req), .i_miss_adr(miss_adr),
    .i_set_valid(set_valid), .i_abort(abort), .o_miss_ack(o_miss_ack),
    .o_bus_cyc(o_bus_cyc), .o_bus_stb(o_bus_stb), .o_bus_adr(o_bus_adr),
    .i_bus_ack(bus_ack), .i_bus_err(bus_err), .i_bus_dat(bus_dat),
    .o_wway(o_wway), .o_cache_we(o_cache_we), .o_cache_beat(o_cache_beat),
    .o_cache_dat(o_cache_dat), .o_fill_done(o_fill_done), .o_fill_err(o_fill_err),
    .o_busy(o_busy)
  );

  function automatic logic [DW-1:0] dat_of(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a, a + 32'd1, {a[15:0], a[31:16]}};
  endfunction

  // Responder: ack (and optionally err on one beat) after ws cycles of strobe.
  int         ws = 0, wcnt = 0;
  bit         err_en = 0;
  logic [1:0] err_beat = '0;
  always @(posedge clk) wcnt <= o_bus_stb ? wcnt + 1 : 0;
  assign bus_ack = o_bus_stb && (wcnt >= ws);
  assign bus_err = o_bus_stb && (wcnt >= ws) && err_en && (o_bus_adr[5:4] == err_beat);
  assign bus_dat = dat_of(o_bus_adr);

  // Reference LFSR: Fibonacci, taps 16,14,13,11.
  logic [15:0] m_lfsr;
  always @(posedge clk)
    m_lfsr <= rst ? SEED : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  typedef struct {
    logic [1:0]  way;
    logic [1:0]  beat;
    logic [31:0] adr;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    if (o_miss_ack) n_ack++;
    if (o_cache_we) begin
      if (n_we == 0) first_we_cyc = cycle;
      n_we++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got beat=%0d adr=%h, required no write", o_cache_beat, o_bus_adr);
      end else begin
        e = sb.pop_front();
        if (o_wway !== e.way || o_cache_beat !== e.beat || o_bus_adr !== e.adr || o_cache_dat !== dat_of(e.adr)) begin
          fails++;
          $display("FAIL write_beat: got way=%0d beat=%0d adr=%h dat=%h, required way=%0d beat=%0d adr=%h dat=%h",
                   o_wway, o_cache_beat, o_bus_adr, o_cache_dat, e.way, e.beat, e.adr, dat_of(e.adr));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; miss_req = 1'b0; abort = 1'b0; err_en = 0; ws = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Raise miss_req and wait for the ack; returns at the negedge of the VICTIM cycle.
  task automatic issue(input logic [31:0] adr, input logic [3:0] valid, input bit hold,
                       output logic [1:0] way);
    bit ok = 0, found = 0;
    miss_adr = adr; set_valid = valid; miss_req = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (o_miss_ack) ok = 1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL miss_ack_timeout: got no ack in 20 cycles, required ack");
    end
    if (!hold) miss_req = 1'b0;
    way = m_lfsr[1:0];
    for (int i = 0; i < 4; i++)
      if (!valid[i] && !found) begin way = 2'(i); found = 1; end
  endtask

  task automatic push_beats(input logic [31:0] adr, input logic [1:0] way, input int n);
    exp_t x;
    for (int b = 0; b < n; b++) begin
      x.way = way; x.beat = 2'(b); x.adr = (adr & 32'hFFFF_FFC0) + 32'(b * 16);
      sb.push_back(x);
    end
  endtask

  task automatic wait_end(input int budget, output int end_cyc, output bit got_done, output bit got_err);
    int c = 0;
    got_done = 0; got_err = 0;
    while (c < budget && !got_done && !got_err) begin
      tick(); c++;
      got_done = o_fill_done; got_err = o_fill_err;
    end
    end_cyc = cycle;
    tests++;
    if (!got_done && !got_err) begin
      fails++;
      $display("FAIL fill_end_timeout: got no done/err in %0d cycles, required one", budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({o_miss_ack, o_bus_cyc, o_bus_stb, o_bus_adr, o_wway, o_cache_we, o_cache_beat,
         o_cache_dat, o_fill_done, o_fill_err, o_busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ack=%b cyc=%b stb=%b adr=%h wway=%0d we=%b busy=%b, required all 0",
               o_miss_ack, o_bus_cyc, o_bus_stb, o_bus_adr, o_wway, o_cache_we, o_busy);
    end
    repeat (3) tick();
    tests++;
    if (o_busy !== 1'b0 || o_bus_cyc !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: got busy=%b cyc=%b, required 0 0", o_busy, o_bus_cyc);
    end
  endtask

  task automatic test_basic_fill();
    logic [1:0] way;
    int ack_cyc, end_cyc;
    bit d, er;
    ws = 0; n_we = 0;
    issue(32'h1234_5678, 4'b1011, 0, way);
    ack_cyc = cycle;
    push_beats(32'h1234_5678, way, 4);
    tick();
    tests++;
    if (o_wway !== 2'd2 || o_bus_adr !== 32'h1234_5640 || o_bus_cyc !== 1'b1 || o_bus_stb !== 1'b1) begin
      fails++;
      $display("FAIL basic_req: got wway=%0d adr=%h cyc=%b stb=%b, required 2 12345640 1 1",
               o_wway, o_bus_adr, o_bus_cyc, o_bus_stb);
    end
    wait_end(60, end_cyc, d, er);
    // Four 3-cycle beats follow the ack cycle, then the DONE cycle.
    tests++;
    if (!d || er || end_cyc - ack_cyc != 13) begin
      fails++;
      $display("FAIL basic_done: got done=%b err=%b at +%0d, required done at +13", d, er, end_cyc - ack_cyc);
    end
    tests++;
    if (first_we_cyc - ack_cyc != 3 || n_we != 4) begin
      fails++;
      $display("FAIL basic_we: got first we +%0d count %0d, required +3 count 4", first_we_cyc - ack_cyc, n_we);
    end
    tick();
    tests++;
    if (o_busy !== 1'b0 || o_fill_done !== 1'b0 || o_bus_cyc !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle: got busy=%b done=%b cyc=%b, required 0 0 0", o_busy, o_fill_done, o_bus_cyc);
    end
  endtask

  task automatic test_lfsr_victim();
    logic [1:0] way;
    logic [3:0] seen = '0;
    int end_cyc;
    bit d, er;
    do_reset();
    repeat (5) tick();
    for (int k = 0; k < 64; k++) begin
      ws = $urandom_range(0, 2);
      miss_adr = $urandom;
      issue(miss_adr, 4'b1111, 0, way);
      push_beats(miss_adr, way, 4);
      tick();
      tests++;
      if (o_wway !== way) begin
        fails++;
        $display("FAIL lfsr_way fill %0d: got %0d, required %0d", k, o_wway, way);
      end
      seen[way] = 1'b1;
      wait_end(80, end_cyc, d, er);
      tests++;
      if (!d) begin
        fails++;
        $display("FAIL lfsr_done fill %0d: got done=%b err=%b, required done", k, d, er);
      end
    end
    tests++;
    if (seen !== 4'b1111) begin
      fails++;
      $display("FAIL lfsr_coverage: got ways seen %b, required 1111", seen);
    end
  endtask

  task automatic test_bus_err();
    logic [1:0] way;
    int end_cyc;
    bit d, er;
    ws = 0; n_we = 0; err_en = 1; err_beat = 2'd2;
    issue(32'h8000_0100, 4'b0000, 0, way);
    push_beats(32'h8000_0100, way, 2);
    wait_end(60, end_cyc, d, er);
    tests++;
    if (!er || d || o_bus_cyc !== 1'b0 || o_bus_stb !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse: got err=%b done=%b cyc=%b stb=%b, required 1 0 0 0", er, d, o_bus_cyc, o_bus_stb);
    end
    tick();
    tests++;
    if (o_busy !== 1'b0 || o_fill_err !== 1'b0 || n_we != 2 || sb.size() != 0) begin
      fails++;
      $display("FAIL err_after: got busy=%b err=%b writes=%0d, required 0 0 2", o_busy, o_fill_err, n_we);
    end
    err_en = 0;
  endtask

  task automatic test_abort();
    logic [1:0] way;
    int end_cyc;
    bit d, er, found = 0, pulse = 0;
    ws = 1; n_we = 0;
    issue(32'h0000_2000, 4'b0001, 0, way);
    push_beats(32'h0000_2000, way, 1);
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (o_bus_stb && bus_ack && o_bus_adr[5:4] == 2'd1) found = 1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL abort_setup: got no beat-1 ack, required one");
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if (o_busy !== 1'b0 || o_bus_cyc !== 1'b0 || o_bus_stb !== 1'b0 || o_cache_we !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got busy=%b cyc=%b stb=%b we=%b, required 0 0 0 0",
               o_busy, o_bus_cyc, o_bus_stb, o_cache_we);
    end
    repeat (6) begin
      tick();
      if (o_fill_done || o_fill_err || o_busy) pulse = 1;
    end
    tests++;
    if (pulse || n_we != 1) begin
      fails++;
      $display("FAIL abort_quiet: got activity=%b writes=%0d, required 0 1", pulse, n_we);
    end
    ws = 0;
    issue(32'h0000_3000, 4'b0011, 0, way);
    push_beats(32'h0000_3000, way, 4);
    tick();
    wait_end(60, end_cyc, d, er);
    tests++;
    if (!d || o_wway !== 2'd2 || n_we != 5) begin
      fails++;
      $display("FAIL abort_refill: got done=%b wway=%0d writes=%0d, required 1 2 5", d, o_wway, n_we);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [1:0] way;
    int end_cyc;
    bit d, er, found = 0;
    ws = 0;
    issue(32'hCAFE_0040, 4'b0111, 0, way);
    push_beats(32'hCAFE_0040, way, 4);
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (o_cache_we && o_cache_beat == 2'd3) found = 1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL rst_setup: got no beat-3 write, required one");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({o_miss_ack, o_bus_cyc, o_bus_stb, o_bus_adr, o_wway, o_cache_we, o_cache_beat,
         o_cache_dat, o_fill_done, o_fill_err, o_busy} !== '0 || sb.size() != 0) begin
      fails++;
      $display("FAIL rst_mid: got cyc=%b we=%b done=%b wway=%0d busy=%b pending=%0d, required all 0",
               o_bus_cyc, o_cache_we, o_fill_done, o_wway, o_busy, sb.size());
    end
    // The victim choice right after reset exposes whether the LFSR was reseeded.
    for (int k = 0; k < 3; k++) begin
      miss_adr = 32'h0001_0000 + 32'(k * 64);
      issue(miss_adr, 4'b1111, 0, way);
      push_beats(miss_adr, way, 4);
      tick();
      tests++;
      if (o_wway !== way) begin
        fails++;
        $display("FAIL rst_lfsr fill %0d: got way %0d, required %0d", k, o_wway, way);
      end
      wait_end(60, end_cyc, d, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] way;
    int end_cyc, ack0;
    bit d, er;
    ws = 0;
    ack0 = n_ack;
    issue(32'h0000_4400, 4'b1110, 1, way);
    push_beats(32'h0000_4400, way, 4);
    wait_end(60, end_cyc, d, er);
    tests++;
    if (!d || n_ack - ack0 != 1) begin
      fails++;
      $display("FAIL hold_first: got done=%b acks=%0d, required 1 1", d, n_ack - ack0);
    end
    tick();
    tests++;
    if (o_miss_ack !== 1'b0) begin
      fails++;
      $display("FAIL hold_early_ack: got ack=%b one cycle after done, required 0", o_miss_ack);
    end
    tick();
    tests++;
    if (o_miss_ack !== 1'b1) begin
      fails++;
      $display("FAIL hold_second_ack: got ack=%b two cycles after done, required 1", o_miss_ack);
    end
    miss_req = 1'b0;
    push_beats(32'h0000_4400, 2'd0, 4);
    wait_end(60, end_cyc, d, er);
    tests++;
    if (!d || sb.size() != 0) begin
      fails++;
      $display("FAIL hold_second_fill: got done=%b pending=%0d, required 1 0", d, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_lfsr_victim();
    test_bus_err();
    test_abort();
    test_reset_mid_fill();
    test_back_to_back();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
